// File: rtl/fft_2_pipe.sv
// fft_2_pipe: 3-stage streaming radix-2 butterfly, y1 = x1 + w*x2, y2 = x1 - w*x2.
// S1 registers operands and the effective twiddle, S2 forms the rounded complex
// product, S3 adds/subtracts, optionally halves, saturates and drives y.
// A single enable (= in_ready) freezes every stage, so a stall never drops
// or duplicates a sample.
module fft_2_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int TW_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] x1_r,
    input  logic signed [DATA_WIDTH-1:0] x1_i,
    input  logic signed [DATA_WIDTH-1:0] x2_r,
    input  logic signed [DATA_WIDTH-1:0] x2_i,
    input  logic signed [TW_WIDTH-1:0]   t_r,
    input  logic signed [TW_WIDTH-1:0]   t_i,
    input  logic                         inverse,
    input  logic                         scale,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] y1_r,
    output logic signed [DATA_WIDTH-1:0] y1_i,
    output logic signed [DATA_WIDTH-1:0] y2_r,
    output logic signed [DATA_WIDTH-1:0] y2_i,
    output logic                         ovf,
    input  logic                         clr_ovf
);

    localparam int DW     = DATA_WIDTH;
    localparam int TW     = TW_WIDTH;
    localparam int PW     = DW + TW + 2;   // full-precision product
    localparam int MW     = DW + 2;        // rounded product, never saturated
    localparam int SW     = DW + 3;        // sum/difference headroom
    localparam int STAGES = 3;

    // half an LSB of the Q1.(TW-2) product, for round-half-up
    localparam logic signed [PW-1:0] RND  = PW'(1) <<< (TW - 3);
    localparam logic signed [SW-1:0] SMAX = SW'((64'sd1 <<< (DW - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] SMIN = SW'(-(64'sd1 <<< (DW - 1)));

    typedef struct packed {
        logic signed [DW-1:0] x1_r;
        logic signed [DW-1:0] x1_i;
        logic signed [DW-1:0] x2_r;
        logic signed [DW-1:0] x2_i;
        logic signed [TW-1:0] w_r;
        logic signed [TW:0]   w_i;     // one extra bit: -(-2^(TW-1)) must fit
        logic                 scale;
    } s1_t;

    typedef struct packed {
        logic signed [DW-1:0] x1_r;
        logic signed [DW-1:0] x1_i;
        logic signed [MW-1:0] m_r;
        logic signed [MW-1:0] m_i;
        logic                 scale;
    } s2_t;

    logic [STAGES:1] vld_pipe;
    logic            en;
    s1_t             s1_d, s1_q;
    s2_t             s2_d, s2_q;

    logic signed [PW-1:0] a_r, a_i, b_r, b_i, p_r, p_i;
    logic signed [SW-1:0] v1_r, v1_i, v2_r, v2_i;
    logic                 any_sat;

    function automatic logic signed [SW-1:0] halve(input logic signed [SW-1:0] v,
                                                   input logic do_it);
        return do_it ? ((v + SW'(1)) >>> 1) : v;
    endfunction

    function automatic logic out_of_range(input logic signed [SW-1:0] v);
        return (v > SMAX) || (v < SMIN);
    endfunction

    function automatic logic signed [DW-1:0] clamp(input logic signed [SW-1:0] v);
        if (v > SMAX) return DW'(SMAX);
        if (v < SMIN) return DW'(SMIN);
        return DW'(v);
    endfunction

    assign out_valid = vld_pipe[STAGES];
    assign in_ready  = !out_valid || out_ready;
    assign en        = in_ready;

    // valid bits march with their data; a stall freezes them all, bubbles included
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else if (en) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
    end

    // S1 input: conjugate the twiddle here so later stages never see inverse
    always_comb begin
        s1_d       = '0;
        s1_d.x1_r  = x1_r;
        s1_d.x1_i  = x1_i;
        s1_d.x2_r  = x2_r;
        s1_d.x2_i  = x2_i;
        s1_d.w_r   = t_r;
        s1_d.w_i   = inverse ? -(TW+1)'(t_i) : (TW+1)'(t_i);
        s1_d.scale = scale;
    end

    // S1 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s1_q <= '0;
        else if (en && in_valid) s1_q <= s1_d;
    end

    // S2 input: complex multiply at full precision, then round half-up to data scale
    always_comb begin
        a_r = PW'(s1_q.x2_r);
        a_i = PW'(s1_q.x2_i);
        b_r = PW'(s1_q.w_r);
        b_i = PW'(s1_q.w_i);
        p_r = a_r * b_r - a_i * b_i;
        p_i = a_r * b_i + a_i * b_r;
        s2_d       = '0;
        s2_d.x1_r  = s1_q.x1_r;
        s2_d.x1_i  = s1_q.x1_i;
        s2_d.m_r   = MW'((p_r + RND) >>> (TW - 2));
        s2_d.m_i   = MW'((p_i + RND) >>> (TW - 2));
        s2_d.scale = s1_q.scale;
    end

    // S2 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s2_q <= '0;
        else if (en && vld_pipe[1]) s2_q <= s2_d;
    end

    // S3 input: butterfly add/sub with optional rounded halving
    always_comb begin
        v1_r = halve(SW'(s2_q.x1_r) + SW'(s2_q.m_r), s2_q.scale);
        v1_i = halve(SW'(s2_q.x1_i) + SW'(s2_q.m_i), s2_q.scale);
        v2_r = halve(SW'(s2_q.x1_r) - SW'(s2_q.m_r), s2_q.scale);
        v2_i = halve(SW'(s2_q.x1_i) - SW'(s2_q.m_i), s2_q.scale);
        any_sat = out_of_range(v1_r) || out_of_range(v1_i) ||
                  out_of_range(v2_r) || out_of_range(v2_i);
    end

    // S3 / output register: y only moves when a real sample lands here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y1_r <= '0;
            y1_i <= '0;
            y2_r <= '0;
            y2_i <= '0;
        end else if (en && vld_pipe[2]) begin
            y1_r <= clamp(v1_r);
            y1_i <= clamp(v1_i);
            y2_r <= clamp(v2_r);
            y2_i <= clamp(v2_i);
        end
    end

    // sticky overflow: a saturating sample landing in y beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf <= 1'b0;
        else if (en && vld_pipe[2] && any_sat) ovf <= 1'b1;
        else if (clr_ovf) ovf <= 1'b0;
    end

endmodule

// File: tb/tb_fft_2_pipe.sv
// tb_fft_2_pipe: directed steps plus a randomized stream, all checked against a
// plain-arithmetic butterfly model through an in-order expected-output queue.
module tb_fft_2_pipe;

    localparam int DW = 16;
    localparam int TW = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_ready, out_valid, out_ready;
    logic signed [DW-1:0] x1_r, x1_i, x2_r, x2_i;
    logic signed [TW-1:0] t_r, t_i;
    logic inverse, scale, ovf, clr_ovf;
    logic signed [DW-1:0] y1_r, y1_i, y2_r, y2_i;

    fft_2_pipe #(.DATA_WIDTH(DW), .TW_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x1_r(x1_r), .x1_i(x1_i), .x2_r(x2_r), .x2_i(x2_i),
        .t_r(t_r), .t_i(t_i), .inverse(inverse), .scale(scale),
        .out_valid(out_valid), .out_ready(out_ready),
        .y1_r(y1_r), .y1_i(y1_i), .y2_r(y2_r), .y2_i(y2_i),
        .ovf(ovf), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct { int x1r, x1i, x2r, x2i, tr, ti; bit inv, scl; } smp_t;
    typedef struct { int y1r, y1i, y2r, y2i; bit sat; } res_t;

    res_t expq[$];
    int   tests = 0;
    int   fails = 0;
    bit   exp_ovf = 0;
    bit   hold_prev = 0;
    int   got_cnt = 0;
    int   last_y1r, last_y1i, last_y2r, last_y2i;
    bit   acc, ir_seen;

    task automatic chk(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic smp_t mk(int a, int b, int c, int d, int e, int f, bit inv, bit scl);
        smp_t s;
        s.x1r = a; s.x1i = b; s.x2r = c; s.x2i = d; s.tr = e; s.ti = f;
        s.inv = inv; s.scl = scl;
        return s;
    endfunction

    // rounded product is kept at DW+2 bits and simply wraps
    function automatic longint wrap_m(longint v);
        return ((v + 131072) & 262143) - 131072;
    endfunction

    function automatic longint scl_v(longint v, bit scl);
        return scl ? ((v + 1) >>> 1) : v;
    endfunction

    function automatic int fin(longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic bit oor(longint v);
        return (v > 32767) || (v < -32768);
    endfunction

    // y1 = x1 + w*x2, y2 = x1 - w*x2 with w in Q1.14, conj(w) when inverse
    function automatic res_t model(smp_t s);
        res_t r;
        longint wr, wi, pr, pi, mr, mi, s1r, s1i, s2r, s2i;
        wr = s.tr;
        wi = s.inv ? -longint'(s.ti) : longint'(s.ti);
        pr = s.x2r * wr - s.x2i * wi;
        pi = s.x2r * wi + s.x2i * wr;
        mr = wrap_m((pr + 8192) >>> 14);
        mi = wrap_m((pi + 8192) >>> 14);
        s1r = scl_v(s.x1r + mr, s.scl);
        s1i = scl_v(s.x1i + mi, s.scl);
        s2r = scl_v(s.x1r - mr, s.scl);
        s2i = scl_v(s.x1i - mi, s.scl);
        r.y1r = fin(s1r); r.y1i = fin(s1i); r.y2r = fin(s2r); r.y2i = fin(s2i);
        r.sat = oor(s1r) || oor(s1i) || oor(s2r) || oor(s2i);
        return r;
    endfunction

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // one clock: drive at edge+1, check at edge+2, advance to next edge+1
    task automatic cyc(input bit iv, input smp_t s, input bit ordy);
        res_t e;
        in_valid = iv; out_ready = ordy;
        x1_r = 16'(s.x1r); x1_i = 16'(s.x1i); x2_r = 16'(s.x2r); x2_i = 16'(s.x2i);
        t_r = 16'(s.tr); t_i = 16'(s.ti); inverse = s.inv; scale = s.scl;
        #1;
        acc = 0;
        ir_seen = in_ready;
        chk("in_ready", in_ready, !out_valid || ordy);
        if (hold_prev) chk("hold_valid", out_valid, 1);
        if (out_valid) begin
            if (expq.size() == 0) chk("spurious_out", out_valid, 0);
            else begin
                e = expq[0];
                chk("y1_r", y1_r, e.y1r);
                chk("y1_i", y1_i, e.y1i);
                chk("y2_r", y2_r, e.y2r);
                chk("y2_i", y2_i, e.y2i);
                if (ordy) begin
                    void'(expq.pop_front());
                    exp_ovf = exp_ovf | e.sat;
                    chk("ovf", ovf, exp_ovf);
                    last_y1r = y1_r; last_y1i = y1_i; last_y2r = y2_r; last_y2i = y2_i;
                    got_cnt++;
                end
            end
        end
        hold_prev = out_valid && !ordy;
        if (iv && in_ready) begin
            expq.push_back(model(s));
            acc = 1;
        end
        @(posedge clk);
        #1;
    endtask

    // send one sample, wait (bounded) for it to emerge; returns idle cycles waited
    task automatic send_one(input smp_t s, output int lat);
        int snap;
        smp_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
        snap = got_cnt;
        cyc(1, s, 1);
        lat = 0;
        while (got_cnt == snap && lat < 10) begin
            cyc(0, idle, 1);
            lat++;
        end
        chk("send_timeout", got_cnt - snap, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        smp_t idle, s;
        int lat, k, rx, c, snap;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0; in_valid = 0; out_ready = 0; clr_ovf = 0;
        x1_r = 0; x1_i = 0; x2_r = 0; x2_i = 0; t_r = 0; t_i = 0; inverse = 0; scale = 0;

        // reset state
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y1_r", y1_r, 0);
        chk("rst_y2_i", y2_i, 0);
        chk("rst_ovf", ovf, 0);
        do_reset();

        // basic butterfly and latency
        send_one(mk(100, 0, 50, 0, 16384, 0, 0, 0), lat);
        chk("t1_latency", lat, 3);
        chk("t1_y1_r", last_y1r, 150);
        chk("t1_y1_i", last_y1i, 0);
        chk("t1_y2_r", last_y2r, 50);
        chk("t1_y2_i", last_y2i, 0);
        chk("t1_pulse", out_valid, 0);
        chk("t1_ovf", ovf, 0);

        // twiddle -j, forward then inverse
        send_one(mk(10, 0, 0, 100, 0, -16384, 0, 0), lat);
        chk("t2_fwd_y1_r", last_y1r, 110);
        chk("t2_fwd_y2_r", last_y2r, -90);
        send_one(mk(10, 0, 0, 100, 0, -16384, 1, 0), lat);
        chk("t2_inv_y1_r", last_y1r, -90);
        chk("t2_inv_y2_r", last_y2r, 110);
        chk("t2_inv_y1_i", last_y1i, 0);

        // 8-sample stream with a downstream stall in cycles 4..8
        k = 0; rx = 0; c = 0; snap = got_cnt;
        while (got_cnt - snap < 8 && c < 40) begin
            s = mk(k, 0, 0, 0, 16384, 0, 0, 0);
            cyc(k < 8, s, !(c >= 4 && c <= 8));
            if (acc) k++;
            if (c >= 4 && c <= 8) chk("stall_in_ready", ir_seen, 0);
            if (got_cnt - snap > rx) begin
                chk("stream_order", last_y1r, rx);
                rx++;
            end
            c++;
        end
        chk("stream_count", got_cnt - snap, 8);

        // saturation, sticky ovf and clear
        send_one(mk(32767, 0, 32767, 0, 16384, 0, 0, 0), lat);
        chk("sat_y1_r", last_y1r, 32767);
        chk("sat_y2_r", last_y2r, 0);
        cyc(0, idle, 1);
        cyc(0, idle, 1);
        chk("sat_ovf_sticky", ovf, 1);
        clr_ovf = 1;
        cyc(0, idle, 1);
        clr_ovf = 0;
        exp_ovf = 0;
        chk("ovf_cleared", ovf, 0);
        send_one(mk(32767, 0, 32767, 0, 16384, 0, 0, 1), lat);
        chk("sat_scl_y1_r", last_y1r, 32767);
        chk("sat_scl_y2_r", last_y2r, 0);
        chk("sat_scl_ovf", ovf, 0);

        // rounding
        send_one(mk(3, -3, 0, 0, 16384, 0, 0, 1), lat);
        chk("rnd_y1_r", last_y1r, 2);
        chk("rnd_y1_i", last_y1i, -1);
        chk("rnd_y2_r", last_y2r, 2);
        chk("rnd_y2_i", last_y2i, -1);
        send_one(mk(0, 0, 1, 0, 8192, 0, 0, 0), lat);
        chk("rnd_half_y1_r", last_y1r, 1);
        chk("rnd_half_y2_r", last_y2r, -1);

        // randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            s = mk(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(),
                   bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
            cyc($urandom_range(0, 9) < 7, s, $urandom_range(0, 9) < 7);
        end
        for (int i = 0; i < 30 && expq.size() != 0; i++) cyc(0, idle, 1);
        chk("drain_empty", expq.size(), 0);

        // reset with samples in flight and a saturated sample sitting in y
        cyc(1, mk(32767, 0, 32767, 0, 16384, 0, 0, 0), 0);
        cyc(1, mk(5, 0, 0, 0, 16384, 0, 0, 0), 0);
        cyc(1, mk(6, 0, 0, 0, 16384, 0, 0, 0), 0);
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_ovf", ovf, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_y1_r", y1_r, 0);
        chk("mid_rst_y1_i", y1_i, 0);
        chk("mid_rst_y2_r", y2_r, 0);
        chk("mid_rst_y2_i", y2_i, 0);
        chk("mid_rst_ovf", ovf, 0);
        expq.delete();
        exp_ovf = 0;
        hold_prev = 0;
        in_valid = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("post_rst_no_out", out_valid, 0);
            cyc(0, idle, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
